// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO burst reader: FSM state codes and the
// counter-width helper.
package fifo_rd_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // Width that can hold every value 0..burst_max inclusive.
    function automatic int len_width(input int burst_max);
        return $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order buffer with independent push/pop and an occupancy count.
// The head entry is always presented and stays put until it is popped.
module stream_skid_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // The caller's credit scheme must keep these from ever firing.
    overflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && occ == 2'd2));
    underflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(pop && occ == 2'd0));

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer for the dual-clock FIFO: pops a clamped burst of
// words, absorbs the FIFO's one-cycle read latency and emits a valid/ready stream.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int BURST_MAX  = 16,
    parameter int LEN_W      = len_width(BURST_MAX)
) (
    input  logic                  clk_rd,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  out_valid,
    output logic [FIFO_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(BURST_MAX);

    logic [1:0]          state;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    issued;
    logic [LEN_W-1:0]    captured;
    logic                pend;
    logic [LEN_W-1:0]    len_req;
    logic [1:0]          occ;
    logic                pop;
    logic                credit_ok;
    logic                cap_last;
    logic [FIFO_WIDTH:0] head;

    assign len_req = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;

    assign pop       = out_valid & out_ready;
    // Words buffered plus the one in flight, less the one leaving, must stay below 2.
    assign credit_ok = ({1'b0, occ} + {2'b00, pend}) < (3'd2 + {2'b00, pop});

    assign fifo_rd_en = rst & (state == READ) & ~fifo_empty & (issued < len) & credit_ok;

    assign cap_last = (captured == len - 1'b1);

    stream_skid_buf #(
        .W (FIFO_WIDTH + 1)
    ) u_buf (
        .clk       (clk_rd),
        .rst       (rst),
        .push      (pend),
        .push_data ({cap_last, fifo_rd_data}),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign out_valid = (occ != 2'd0);
    assign out_data  = head[FIFO_WIDTH-1:0];
    assign out_last  = out_valid & head[FIFO_WIDTH];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_rd) begin
        if (!rst) begin
            state    <= IDLE;
            len      <= '0;
            issued   <= '0;
            captured <= '0;
            pend     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            pend <= fifo_rd_en;
            if (fifo_rd_en) begin
                issued <= issued + 1'b1;
            end
            if (pend) begin
                captured <= captured + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_req == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= READ;
                            len      <= len_req;
                            issued   <= '0;
                            captured <= '0;
                        end
                    end
                end
                READ: begin
                    if (issued == len) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT and every
// accepted word is compared against the FIFO's global word order.
module tb_fifo_burst_reader;

    localparam int FW = 8;
    localparam int BM = 16;
    localparam int LW = $clog2(BM + 1);

    logic          clk_rd = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          busy;
    logic          done;
    logic          fifo_rd_en;
    logic [FW-1:0] fifo_rd_data = '0;
    logic          fifo_empty = 1'b1;
    logic          out_valid;
    logic [FW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [FW-1:0] fq[$];
    logic [FW-1:0] all_words[$];
    int total_pops = 0;
    int cyc_first;
    int cyc_done;

    fifo_burst_reader #(.FIFO_WIDTH(FW), .BURST_MAX(BM)) dut (
        .clk_rd       (clk_rd),
        .rst          (rst),
        .start        (start),
        .burst_len    (burst_len),
        .busy         (busy),
        .done         (done),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready)
    );

    always #5 clk_rd = ~clk_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [FW-1:0] w);
        fq.push_back(w);
        all_words.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Close the current cycle: the FIFO pops on the edge if a read was issued,
    // otherwise its output shows junk that must never be captured.
    task automatic advance(input bit fire);
        @(posedge clk_rd);
        #1;
        if (fire) begin
            fifo_rd_data = fq.pop_front();
            total_pops++;
        end else begin
            fifo_rd_data = FW'($urandom);
        end
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic set_ready(input int rmode, input int cyc);
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 3) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Runs one burst from its start cycle (cycle 0) and checks it against the
    // expected slice of the FIFO word stream. rst_at_acc>0 resets once that many
    // words have been accepted and then checks the block is idle.
    task automatic run_burst(input int req, input int rmode, input int refill_at,
                             input int refill_n, input int busy_start_at, input int rst_at_acc);
        int len, base, acc, pops, cyc, last_acc_cyc;
        bit seen_done, prev_stall, fire;
        logic [FW-1:0] prev_d;
        logic prev_l;
        len = (req > BM) ? BM : req;
        acc = 0; pops = 0; cyc = 0; last_acc_cyc = -1;
        seen_done = 0; prev_stall = 0; prev_d = '0; prev_l = 1'b0;
        cyc_first = -1; cyc_done = -1;
        @(posedge clk_rd);
        #1;
        base = total_pops;
        start = 1'b1;
        burst_len = LW'(req);
        set_ready(rmode, 0);
        while (!seen_done && cyc < 400) begin
            @(negedge clk_rd);
            if (fifo_empty) chk("rd_en_while_empty", 32'(fifo_rd_en), 0);
            chk("outstanding_le_2", 32'((pops - acc) <= 2), 1);
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(prev_d));
                chk("hold_last", 32'(out_last), 32'(prev_l));
            end
            if (out_valid && cyc_first < 0) cyc_first = cyc;
            fire = fifo_rd_en && !fifo_empty;
            if (fire) pops++;
            if (out_valid && out_ready) begin
                chk("word_in_range", 32'(acc < len), 1);
                if (acc < len && base + acc < all_words.size())
                    chk("data", 32'(out_data), 32'(all_words[base + acc]));
                chk("last", 32'(out_last), 32'(acc == len - 1));
                acc++;
                last_acc_cyc = cyc;
            end
            if (done) begin
                seen_done = 1;
                cyc_done = cyc;
                chk("done_cycle", cyc, (len == 0) ? 1 : last_acc_cyc + 1);
                chk("busy_at_done", 32'(busy), 0);
            end else begin
                chk("busy", 32'(busy), 32'(len != 0 && cyc >= 1));
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            if (rst_at_acc > 0 && acc == rst_at_acc) begin
                advance(fire);
                rst = 1'b0;
                start = 1'b0;
                advance(1'b0);
                rst = 1'b1;
                @(negedge clk_rd);
                chk("rst_mid_busy", 32'(busy), 0);
                chk("rst_mid_valid", 32'(out_valid), 0);
                chk("rst_mid_rd_en", 32'(fifo_rd_en), 0);
                chk("rst_mid_done", 32'(done), 0);
                return;
            end
            advance(fire);
            cyc++;
            start = (cyc == busy_start_at);
            if (start) burst_len = LW'(3);
            set_ready(rmode, cyc);
            if (cyc == refill_at)
                for (int i = 0; i < refill_n; i++) push_word(FW'($urandom));
        end
        chk("done_seen", 32'(seen_done), 1);
        chk("pop_count", pops, len);
        chk("accept_count", acc, len);
        start = 1'b0;
        advance(1'b0);
        @(negedge clk_rd);
        chk("idle_after_done", 32'(done), 0);
        chk("idle_after_busy", 32'(busy), 0);
        chk("idle_after_rd_en", 32'(fifo_rd_en), 0);
    endtask

    initial begin
        int n, k;
        rst = 1'b0;
        start = 1'b1;
        burst_len = LW'(4);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk_rd);
            #1;
            @(negedge clk_rd);
            chk("reset_busy", 32'(busy), 0);
            chk("reset_done", 32'(done), 0);
            chk("reset_rd_en", 32'(fifo_rd_en), 0);
            chk("reset_valid", 32'(out_valid), 0);
            chk("reset_last", 32'(out_last), 0);
            chk("reset_data", 32'(out_data), 0);
        end
        @(posedge clk_rd);
        #1;
        rst = 1'b1;
        start = 1'b0;

        // Burst of 4 with a preloaded FIFO and full throughput.
        for (int i = 0; i < 4; i++) push_word(FW'(8'hA0 + i));
        run_burst(4, 0, -1, 0, -1, 0);
        chk("b4_first_valid_cyc", cyc_first, 3);
        chk("b4_done_cyc", cyc_done, 7);

        // Backpressure with ready pattern 1,0,0 repeating.
        for (int i = 0; i < 5; i++) push_word(FW'($urandom));
        run_burst(5, 1, -1, 0, -1, 0);

        // FIFO runs dry after 2 words; 3 more arrive 10 cycles in.
        for (int i = 0; i < 2; i++) push_word(FW'($urandom));
        run_burst(5, 0, 10, 3, -1, 0);

        // Zero-length burst.
        run_burst(0, 0, -1, 0, -1, 0);
        chk("len0_no_valid", cyc_first, -1);

        // Oversized request clamps to BURST_MAX; a start while busy is ignored.
        for (int i = 0; i < 20; i++) push_word(FW'($urandom));
        run_burst(31, 2, -1, 0, 5, 0);

        // Random bursts with random backpressure and late refills.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, BM);
            k = $urandom_range(0, n);
            for (int i = 0; i < k; i++) push_word(FW'($urandom));
            run_burst(n, 2, $urandom_range(2, 20), n - k, -1, 0);
        end

        // Reset after 2 of 6 words, then a fresh burst of 2.
        for (int i = 0; i < 8; i++) push_word(FW'($urandom));
        run_burst(6, 0, -1, 0, -1, 2);
        run_burst(2, 0, -1, 0, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
